// File: rtl/io_out_pkg.sv
// io_out_pkg: shared widths and entry field offsets for the io_out output buffer.
// Entries are packed as {addr, data[, ts]} with ts in the low bits when IO_OUT_TS_EN is defined.
// Optional feature macro: IO_OUT_TS_EN (adds a per-entry timestamp field).
package io_out_pkg;
`ifdef IO_OUT_TS_EN
    localparam int TS_ON = 1;
`else
    localparam int TS_ON = 0;
`endif
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int entry_w(input int nb, input int aw);
        return aw + nb + TS_ON * nb;
    endfunction
    function automatic int data_lsb(input int nb);
        return TS_ON * nb;
    endfunction
    function automatic int addr_lsb(input int nb);
        return data_lsb(nb) + nb;
    endfunction
    localparam int ENTRY_W = entry_w(32, ptr_w(8));
endpackage

// File: rtl/io_out_mem.sv
// io_out_mem: DEPTH x W register array, synchronous write, combinational read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
module io_out_mem
    import io_out_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ENTRY_W
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [W-1:0]            wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [W-1:0]            rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/io_out_buf.sv
// io_out_buf: FIFO between core OUT writes and a valid/ready peripheral consumer.
// Ports: clk, rst (sync, active-high); out_en/addr_out/data_out core write side;
// m_valid/m_addr/m_data/m_ready first-word-fall-through head; full/afull/count status;
// ovf sticky overflow with ovf_clr. With IO_OUT_TS_EN: m_ts head timestamp.
module io_out_buf
    import io_out_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8,
    parameter int AFULL  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      out_en,
    input  logic [ptr_w(NUIOOU)-1:0]  addr_out,
    input  logic [NUBITS-1:0]         data_out,
    output logic                      m_valid,
    output logic [ptr_w(NUIOOU)-1:0]  m_addr,
    output logic [NUBITS-1:0]         m_data,
`ifdef IO_OUT_TS_EN
    output logic [NUBITS-1:0]         m_ts,
`endif
    input  logic                      m_ready,
    output logic                      full,
    output logic                      afull,
    output logic [$clog2(FDEPTH):0]   count,
    output logic                      ovf,
    input  logic                      ovf_clr
);
    localparam int AW = ptr_w(NUIOOU);
    localparam int PW = ptr_w(FDEPTH);
    localparam int CW = $clog2(FDEPTH) + 1;
    localparam int EW = entry_w(NUBITS, AW);
    localparam int DL = data_lsb(NUBITS);
    localparam int AL = addr_lsb(NUBITS);
    logic [PW-1:0] wp, rp;
    logic [EW-1:0] wdata, rdata;
    logic pop, acc;
    assign pop   = m_valid & m_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign acc   = out_en & (~full | pop);
    assign m_valid = count != '0;
    assign full    = count == CW'(FDEPTH);
    assign afull   = count >= CW'(AFULL);
    assign m_addr  = m_valid ? rdata[AL +: AW] : '0;
    assign m_data  = m_valid ? rdata[DL +: NUBITS] : '0;
`ifdef IO_OUT_TS_EN
    logic [NUBITS-1:0] ts;
    always_ff @(posedge clk)
        ts <= rst ? '0 : ts + NUBITS'(1);
    assign wdata = {addr_out, data_out, ts};
    assign m_ts  = m_valid ? rdata[0 +: NUBITS] : '0;
`else
    assign wdata = {addr_out, data_out};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            wp    <= acc ? wp + PW'(1) : wp;
            rp    <= pop ? rp + PW'(1) : rp;
            count <= count + CW'(acc) - CW'(pop);
            // a new overflow wins over a clear in the same cycle
            ovf   <= (out_en & ~acc) | (ovf & ~ovf_clr);
        end
    end
    io_out_mem #(.DEPTH(FDEPTH), .W(EW)) u_mem (
        .clk   (clk),
        .we    (acc & ~rst),
        .waddr (wp),
        .wdata (wdata),
        .raddr (rp),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_io_out_buf.sv
// tb_io_out_buf: directed scoreboard bench for io_out_buf (default parameters).
module tb_io_out_buf;
    localparam int FD = 8;
    localparam int AF = 6;
    typedef struct packed {
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] t;
    } ent_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_en = 1'b0;
    logic [2:0]  addr_out = '0;
    logic [31:0] data_out = '0;
    logic        m_valid;
    logic [2:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;
    logic        full, afull, ovf;
    logic [3:0]  count;
    logic        ovf_clr = 1'b0;
`ifdef IO_OUT_TS_EN
    logic [31:0] m_ts;
`endif
    ent_t q[$];
    logic ovf_m = 1'b0;
    logic [31:0] ts_m = '0;
    int tests = 0;
    int fails = 0;
    io_out_buf #(.NUBITS(32), .NUIOOU(8), .FDEPTH(FD), .AFULL(AF)) dut (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en),
        .addr_out (addr_out),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_data   (m_data),
`ifdef IO_OUT_TS_EN
        .m_ts     (m_ts),
`endif
        .m_ready  (m_ready),
        .full     (full),
        .afull    (afull),
        .count    (count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_state();
        chk("count", 64'(count), 64'(q.size()));
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        chk("full", 64'(full), 64'(q.size() == FD));
        chk("afull", 64'(afull), 64'(q.size() >= AF));
        chk("ovf", 64'(ovf), 64'(ovf_m));
        chk("m_addr", 64'(m_addr), q.size() != 0 ? 64'(q[0].a) : 64'd0);
        chk("m_data", 64'(m_data), q.size() != 0 ? 64'(q[0].d) : 64'd0);
`ifdef IO_OUT_TS_EN
        chk("m_ts", 64'(m_ts), q.size() != 0 ? 64'(q[0].t) : 64'd0);
`endif
    endtask
    task automatic cyc(input logic en, input logic [2:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
        logic pop, acc, nov;
        ent_t e;
        out_en = en; addr_out = a; data_out = d; m_ready = rdy; ovf_clr = clr;
        #1;
        pop = (q.size() != 0) && rdy;
        acc = en && (q.size() < FD || pop);
        nov = (en && !acc) || (ovf_m && !clr);
        e = '{a: a, d: d, t: ts_m};
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        ovf_m = nov;
        ts_m++;
        @(negedge clk);
        check_state();
    endtask
    task automatic do_rst(input logic en);
        rst = 1'b1; out_en = en; addr_out = 3'd7; data_out = 32'hDEAD; m_ready = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        q.delete();
        ovf_m = 1'b0;
        ts_m = '0;
        @(negedge clk);
        rst = 1'b0; out_en = 1'b0;
        check_state();
    endtask
    initial begin
        @(negedge clk);
        do_rst(1'b0);
        cyc(1, 3'd1, 32'h11, 0, 0);
        cyc(1, 3'd2, 32'h22, 0, 0);
        cyc(1, 3'd3, 32'h33, 0, 0);
        cyc(0, 3'd0, 32'h0, 0, 0);
        chk("hold_addr", 64'(m_addr), 64'd1);
        chk("hold_data", 64'(m_data), 64'h11);
        for (int i = 0; i < 3; i++) cyc(0, 3'd0, 32'h0, 1, 0);
        chk("drained", 64'(count), 64'd0);
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 32'h100 + 32'(i), 0, 0);
        cyc(1, 3'd5, 32'hBAD, 0, 0);
        chk("ovf_set", 64'(ovf), 64'd1);
        cyc(0, 3'd0, 32'h0, 0, 1);
        chk("ovf_clr", 64'(ovf), 64'd0);
        cyc(1, 3'd5, 32'hAB, 1, 0);
        chk("full_pp_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 8; i++) cyc(0, 3'd0, 32'h0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(1, 3'(i % 8), 32'(i), 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 3'd0, 32'h0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 3'(7 - i), 32'h200 + 32'(i), 0, 0);
        cyc(1, 3'd2, 32'hBAD2, 0, 1);
        chk("ovf_set_wins", 64'(ovf), 64'd1);
        for (int i = 0; i < 8; i++) cyc(0, 3'd0, 32'h0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 3'(i), 32'h300 + 32'(i), 0, 0);
        do_rst(1'b1);
        chk("rst_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) cyc(0, 3'd0, 32'h0, 0, 0);
        cyc(1, 3'd4, 32'h44, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 3'd0, 32'h0, 0, 0);
        cyc(1, 3'd6, 32'h99, 0, 0);
`ifdef IO_OUT_TS_EN
        chk("ts_first", 64'(m_ts), 64'd4);
`endif
        cyc(0, 3'd0, 32'h0, 1, 0);
`ifdef IO_OUT_TS_EN
        chk("ts_second", 64'(m_ts), 64'd9);
`endif
        cyc(0, 3'd0, 32'h0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
